// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, instruction-buffer
// entry layout and small arithmetic helpers.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam int INST_W   = 32;
  localparam int PC_STEP  = 4;
  localparam int PC_MAX_W = 64;

  // Entries always carry a full 64-bit PC; narrower XLEN builds zero-extend into it.
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Instruction buffer for the fetch unit: power-of-two depth FIFO with flush,
// registered head (no combinational bypass) and last-head hold while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_hold;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !w_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count decides validity, and
  // r_hold provides the defined zero head value out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset)         r_hold <= '0;
    else if (!w_empty) r_hold <= r_mem[r_rd_ptr];
  end

  assign o_head  = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps one imem request outstanding and
// buffers {pc, inst} for decode. Define FETCH_STATS_EN to add saturating stat counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_req_pc;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_outstanding;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_after;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign w_accept = (r_state == REQ) && imem_req_ready && !redirect_valid;
  assign w_push   = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop    = inst_valid && inst_ready && !redirect_valid;

  // A response in the redirect cycle retires the outstanding request, so no DROP is needed.
  assign w_outstanding = ((r_state == WAIT || r_state == DROP) && !imem_rsp_valid)
                       || (r_state == REQ && imem_req_ready);

  assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_outstanding ? DROP : REQ;
    end else begin
      unique case (r_state)
        IDLE: if (w_count < CNT_W'(FIFO_DEPTH)) w_state_next = REQ;
        REQ:  if (imem_req_ready) w_state_next = WAIT;
        WAIT: if (imem_rsp_valid)
                w_state_next = (w_count_after < CNT_W'(FIFO_DEPTH)) ? REQ : IDLE;
        DROP: if (imem_rsp_valid) w_state_next = REQ;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_accept) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      end
    end
  end

  assign w_push_entry.pc   = PC_MAX_W'(r_req_pc);
  assign w_push_entry.inst = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = (w_count != '0);
  assign inst_pc        = w_head.pc[XLEN-1:0];
  assign inst_data      = w_head.inst;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_dropped;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_dropped <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_push) r_stat_fetched <= sat_inc32(r_stat_fetched);
      if (imem_rsp_valid && (redirect_valid || r_state == DROP))
        r_stat_dropped <= sat_inc32(r_stat_dropped);
      if (!inst_valid && r_state == WAIT) r_stat_stall <= sat_inc32(r_stat_stall);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_dropped = r_stat_dropped;
  assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench: imem responder with variable latency, a scoreboard queue of
// expected decode-side PCs (sequential from the last redirect) and a pop monitor.
module tb_instruction_fetch_unit;

  localparam int          XLEN       = 64;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [63:0] RESET_PC   = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_dropped;
  logic [31:0] stat_stall;
`endif

  instruction_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  // Stimulus knobs.
  int          ready_pct  = 100;
  int          iready_pct = 100;
  int          lat_max    = 1;
  int          redir_pct  = 0;
  int          coin_pct   = 0;
  bit          force_redir = 1'b0;
  logic [63:0] force_target;

  // Memory responder state.
  bit          pend = 1'b0;
  int          pend_lat;
  logic [63:0] pend_addr;

  // Values sampled at the previous negedge.
  bit          s_accept = 1'b0;
  logic [63:0] s_addr;
  bit          s_hold_pending = 1'b0;
  logic [63:0] s_hold_addr;
  bit          s_redir = 1'b0;
  logic [63:0] s_redir_tgt;
  bit          arm = 1'b0;
  logic [63:0] arm_addr;

  logic [63:0] exp_q[$];
  logic [63:0] gen_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [63:0] random_target();
    case ($urandom_range(2))
      0:       return {32'h0, $urandom()};
      1:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      default: return 64'($urandom_range(4095));
    endcase
  endfunction

  // Scoreboard monitor: every decode handshake must present the next expected PC.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL inst_unexpected: got pc %h, expected nothing queued", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", 64'(inst_data), 64'(mem_word(e)));
        n_pop++;
      end
    end
  end

  task automatic cycle();
    logic [63:0] tgt;
    @(negedge clk);
    s_accept = imem_req_valid && imem_req_ready;
    if (s_hold_pending) begin
      check("req_hold_valid", 64'(imem_req_valid), 64'd1);
      check("req_hold_addr", imem_req_addr, s_hold_addr);
    end
    if (s_redir) begin
      check("flush_after_redirect", 64'(inst_valid), 64'd0);
      arm      = 1'b1;
      arm_addr = s_redir_tgt;
    end
    if (s_accept) begin
      check("req_aligned", 64'(imem_req_addr[1:0]), 64'd0);
      if (arm) begin
        check("req_after_redirect", imem_req_addr, arm_addr);
        arm = 1'b0;
      end
      s_addr = imem_req_addr;
    end
    s_hold_pending = imem_req_valid && !imem_req_ready && !redirect_valid;
    s_hold_addr    = imem_req_addr;
    s_redir        = redirect_valid;
    s_redir_tgt    = {redirect_pc[63:2], 2'b00};

    @(posedge clk);
    #1;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < iready_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (s_accept) begin
      pend      = 1'b1;
      pend_lat  = $urandom_range(lat_max, 1);
      pend_addr = s_addr;
    end
    if (pend) begin
      pend_lat--;
      if (pend_lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    if (force_redir || ($urandom_range(99) < redir_pct) ||
        (imem_rsp_valid && inst_valid && inst_ready && ($urandom_range(99) < coin_pct))) begin
      tgt            = force_redir ? force_target : random_target();
      force_redir    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      exp_q.delete();
      gen_pc = {tgt[63:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 64'd4;
    end
  endtask

  initial begin
    int n0;
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    gen_pc         = RESET_PC;
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 64'd4;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming from reset: always ready, one-cycle latency.
    n0 = n_pop;
    repeat (30) cycle();
    check("stream_rate_ok", 64'(n_pop - n0 >= 12), 64'd1);

    // Decode stalled: buffer fills to exactly FIFO_DEPTH and requests stop.
    iready_pct   = 0;
    force_redir  = 1'b1;
    force_target = 64'h1000;
    repeat (20) cycle();
    check("full_req_valid", 64'(imem_req_valid), 64'd0);
    check("full_inst_valid", 64'(inst_valid), 64'd1);
    check("full_head_pc", inst_pc, 64'h1000);
    iready_pct = 100;
    inst_ready = 1'b1;
    for (int k = 0; k < FIFO_DEPTH - 1; k++) begin
      cycle();
      check("drain_valid", 64'(inst_valid), 64'd1);
    end
    repeat (20) cycle();

    // Redirect with slow memory so the old response arrives late.
    lat_max      = 3;
    force_redir  = 1'b1;
    force_target = 64'h100;
    repeat (20) cycle();

    // Unaligned redirect target.
    force_redir  = 1'b1;
    force_target = 64'h203;
    repeat (20) cycle();

    // PC wrap at the top of the address space.
    lat_max      = 1;
    force_redir  = 1'b1;
    force_target = 64'hFFFF_FFFF_FFFF_FFF8;
    repeat (20) cycle();

    // Randomized traffic, including redirects that coincide with response and pop.
    ready_pct  = 70;
    iready_pct = 60;
    lat_max    = 3;
    redir_pct  = 3;
    coin_pct   = 50;
    n0 = n_pop;
    repeat (3000) cycle();
    check("random_progress_ok", 64'(n_pop - n0 > 200), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the decode/execute datapath. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel with a variable-latency response, and buffers fetched instructions with their PCs in a small FIFO. Decode consumes {pc, instruction} pairs over a valid/ready handshake. A taken branch or jump arrives as a redirect, which flushes the buffer and any in-flight fetch.

Parameters:
XLEN, 64, width of PC and addresses
RESET_PC, 64'h0, fetch PC loaded on reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  XLEN  fetch address (always 4-byte aligned)
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response data valid (one cycle pulse)
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  buffer head valid
inst_ready  input  1  decode accepts head
inst_pc  output  XLEN  PC of head instruction
inst_data  output  32  head instruction word
redirect_valid  input  1  branch/jump taken, flush and refetch
redirect_pc  input  XLEN  new fetch target

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, FIFO empty, state=IDLE; imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_pc=0, inst_data=0.
- One outstanding request maximum. States: IDLE, REQ, WAIT, DROP.
- IDLE -> REQ when free_slots = FIFO_DEPTH - count >= 1; otherwise stay.
- REQ: imem_req_valid=1, addr=fetch_pc. On imem_req_ready: latch req_pc=fetch_pc, fetch_pc+=4 (wraps modulo 2^XLEN), go to WAIT.
- WAIT: on imem_rsp_valid push {req_pc, imem_rsp_data}, then go to REQ if slot free, else IDLE. Response may arrive ≥1 cycle after acceptance; same-cycle response with request is not supported.
- DROP: the next imem_rsp_valid is discarded (no push), then go to REQ.
- Redirect (highest priority, any state): FIFO count=0, fetch_pc=redirect_pc with bits[1:0] forced to 0. State goes to DROP if a request is outstanding (WAIT, or REQ accepted this cycle), else REQ. A response arriving in the redirect cycle is discarded. A redirect during DROP stays in DROP.
- A push and a pop in the same cycle are allowed when full or empty-bypass: count is unchanged. No combinational bypass: data is visible on inst_* the cycle after push (fetch-to-decode latency ≥2 cycles).
- inst_valid = (count != 0); pop when inst_valid & inst_ready & !redirect_valid.
- imem_req_valid is held with a stable address until ready, unless a redirect occurs. On redirect the address changes the same cycle, and abandoning the old request is legal.
- inst_pc/inst_data hold the last head value when empty (don't-care to consumer).

Optional Feature:
FETCH_STATS_EN. When defined, adds outputs stat_fetched (32b, responses pushed), stat_dropped (32b, responses discarded in DROP/redirect) and stat_stall (32b, cycles with inst_valid=0 and state WAIT). All reset to 0 and saturate at all-ones. When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: fetch state enum (IDLE, REQ, WAIT, DROP), INST_W=32, PC_STEP=4, fifo-entry struct {pc, inst}.
- One sub-module: fetch_fifo (parameterised depth/width, push/pop/flush, count, synchronous reset). The FSM and PC logic stay in the top.

Test Plan:
- Reset then imem ready always, 1-cycle rsp latency, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching words; no gaps after warm-up beyond the one-outstanding limit.
- inst_ready=0 for 20 cycles -> exactly FIFO_DEPTH=4 entries buffered (pc 0..12), imem_req_valid drops to 0; release -> pops in order, fetch resumes at pc 16.
- Redirect to 0x100 while in WAIT -> FIFO empties next cycle, the late response for the old pc is dropped (not visible on inst_*), next inst_pc=0x100.
- redirect_pc=0x203 -> request issued at 0x200; inst_pc=0x200.
- Redirect in the same cycle as imem_rsp_valid and inst_ready pop -> no push, no pop side effects, count=0, next request addr=redirect target.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC -> the following request is addr 0; with FETCH_STATS_EN, after test 3 stat_dropped=1.
